// File: rtl/misao_mem.sv
// Byte-wide memory responder for the MISA-O core bus: 1-cycle registered reads, 0-cycle writes.
// Optional image loader (define MISAO_MEM_LOADER_EN) writes a byte stream from address 0; it wins over core writes.
module misao_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_enable_read,
    input  logic          mem_enable_write,
    input  logic [AW-1:0] mem_addr,
    input  logic          mem_rw,
    input  logic [7:0]    mem_data_out,
    output logic [7:0]    mem_data_in,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          loading,
    output logic          load_err,
    output logic          addr_err
);

    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic          in_range;
    logic [IW-1:0] core_idx;
    logic          core_we;
    logic          ld_we;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [7:0]    wr_dat;
    logic          err_set;

    assign in_range = ({1'b0, mem_addr} < DEPTH_W);
    assign core_idx = mem_addr[IW-1:0];

`ifdef MISAO_MEM_LOADER_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    ld_state_t     state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic          err_nxt;
    logic          unused_ok;

    assign unused_ok = mem_rw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            load_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        err_nxt   = load_err;
        ld_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt = ST_LOAD;
                    ptr_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    ld_we = 1'b1;
                    // the pointer saturates at the top byte so an overlong image never wraps
                    if (ptr != IW'(DEPTH-1)) begin
                        ptr_nxt = ptr + 1'b1;
                    end
                    if (load_last) begin
                        state_nxt = ST_DONE;
                    end else if (ptr == IW'(DEPTH-1)) begin
                        state_nxt = ST_DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load_ready = (state == ST_LOAD);
    assign loading    = (state == ST_LOAD);
    assign core_we    = mem_enable_write && in_range && !ld_we;
    assign wr_en      = ld_we || core_we;
    assign wr_idx     = ld_we ? ptr : core_idx;
    assign wr_dat     = ld_we ? load_data : mem_data_out;
    // a core write colliding with a loader write is a protocol violation, flagged like a bad address
    assign err_set    = ((mem_enable_read || mem_enable_write) && !in_range)
                      || (mem_enable_write && ld_we);
`else
    logic unused_ok;

    assign unused_ok  = ^{mem_rw, load_start, load_valid, load_data, load_last};
    assign load_ready = 1'b0;
    assign loading    = 1'b0;
    assign load_err   = 1'b0;
    assign ld_we      = 1'b0;
    assign core_we    = mem_enable_write && in_range;
    assign wr_en      = core_we;
    assign wr_idx     = core_idx;
    assign wr_dat     = mem_data_out;
    assign err_set    = (mem_enable_read || mem_enable_write) && !in_range;
`endif

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // read-before-write: the array update lands after this edge samples the old byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data_in <= 8'h00;
        end else if (mem_enable_read) begin
            mem_data_in <= in_range ? mem[core_idx] : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err <= 1'b0;
        end else if (err_set) begin
            addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_misao_mem.sv
// Directed self-checking bench for misao_mem; loader checks are built when MISAO_MEM_LOADER_EN is defined.
module tb_misao_mem;

    localparam int DEPTH = 256;
    localparam int AW    = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_enable_read;
    logic          mem_enable_write;
    logic [AW-1:0] mem_addr;
    logic          mem_rw;
    logic [7:0]    mem_data_out;
    logic [7:0]    mem_data_in;
    logic          load_start;
    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_last;
    logic          load_ready;
    logic          loading;
    logic          load_err;
    logic          addr_err;

    int checks   = 0;
    int failures = 0;

    misao_mem #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_enable_read  (mem_enable_read),
        .mem_enable_write (mem_enable_write),
        .mem_addr         (mem_addr),
        .mem_rw           (mem_rw),
        .mem_data_out     (mem_data_out),
        .mem_data_in      (mem_data_in),
        .load_start       (load_start),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .loading          (loading),
        .load_err         (load_err),
        .addr_err         (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [AW-1:0] a, input logic [7:0] d);
        mem_enable_write = 1'b1;
        mem_rw           = 1'b1;
        mem_addr         = a;
        mem_data_out     = d;
        cyc();
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
    endtask

    task automatic core_read(input logic [AW-1:0] a, input string tag, input logic [7:0] exp);
        mem_enable_read = 1'b1;
        mem_addr        = a;
        cyc();
        mem_enable_read = 1'b0;
        check(tag, 16'(mem_data_in), 16'(exp));
    endtask

`ifdef MISAO_MEM_LOADER_EN
    int accepted;
    int load_cycles;
`endif

    initial begin
        rst              = 1'b1;
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_addr         = '0;
        mem_rw           = 1'b0;
        mem_data_out     = 8'h00;
        load_start       = 1'b0;
        load_valid       = 1'b0;
        load_data        = 8'h00;
        load_last        = 1'b0;
        cyc();
        cyc();
        check("rst_data_in",    16'(mem_data_in), 16'h00);
        check("rst_load_ready", 16'(load_ready),  16'h0);
        check("rst_loading",    16'(loading),     16'h0);
        check("rst_load_err",   16'(load_err),    16'h0);
        check("rst_addr_err",   16'(addr_err),    16'h0);
        rst = 1'b0;
        cyc();

        core_write(15'h000, 8'h05);
        core_read(15'h000, "wr_rd_05", 8'h05);
        core_write(15'h000, 8'h09);
        core_read(15'h000, "wr_rd_09", 8'h09);

        core_write(15'h010, 8'hAA);
        mem_enable_read  = 1'b1;
        mem_enable_write = 1'b1;
        mem_addr         = 15'h010;
        mem_data_out     = 8'h55;
        cyc();
        mem_enable_write = 1'b0;
        mem_enable_read  = 1'b0;
        check("collide_old", 16'(mem_data_in), 16'hAA);
        core_read(15'h010, "collide_new", 8'h55);

        mem_addr = 15'h000;
        cyc();
        cyc();
        check("strobe_low_hold", 16'(mem_data_in), 16'h55);
        check("no_addr_err_yet", 16'(addr_err), 16'h0);

        core_write(15'h0100, 8'h77);
        check("oor_wr_err", 16'(addr_err), 16'h1);
        core_read(15'h0100, "oor_rd_zero", 8'h00);
        core_read(15'h000, "oor_no_alias", 8'h09);
        core_read(15'h7FFF, "oor_top_zero", 8'h00);
        check("addr_err_sticky", 16'(addr_err), 16'h1);

        rst = 1'b1;
        #1;
        check("rst_clears_addr_err", 16'(addr_err), 16'h0);
        cyc();
        rst = 1'b0;
        cyc();
        core_read(15'h010, "array_survives_rst", 8'h55);

`ifdef MISAO_MEM_LOADER_EN
        // normal three-byte image
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        check("ld_ready_after_start", 16'(load_ready), 16'h1);
        load_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = (i == 0) ? 8'h18 : (i == 1) ? 8'h0C : 8'h54;
            load_last  = (i == 2);
            if (loading && load_ready) load_cycles++;
            cyc();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("ld_loading_cycles", 16'(load_cycles), 16'd3);
        check("ld_ready_fell", 16'(load_ready), 16'h0);
        check("ld_loading_fell", 16'(loading), 16'h0);
        cyc();
        check("ld_err_clean", 16'(load_err), 16'h0);
        core_read(15'h000, "ld_b0", 8'h18);
        core_read(15'h001, "ld_b1", 8'h0C);
        core_read(15'h002, "ld_b2", 8'h54);

        // overlong image: byte 257 must be refused
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        accepted   = 0;
        for (int i = 0; i < 257; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i) ^ 8'h3C;
            if (load_ready) accepted++;
            cyc();
        end
        load_valid = 1'b0;
        check("ovf_accepted", 16'(accepted), 16'd256);
        check("ovf_load_err", 16'(load_err), 16'h1);
        check("ovf_idle", 16'(loading), 16'h0);
        core_read(15'h000, "ovf_b0", 8'h3C);
        core_read(15'h0FF, "ovf_b255", 8'hC3);
        core_read(15'h080, "ovf_b128", 8'hBC);

        // reset in the middle of a load
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'hA1;
        cyc();
        load_data  = 8'hA2;
        cyc();
        load_data  = 8'hA3;
        rst = 1'b1;
        #1;
        check("midrst_loading", 16'(loading), 16'h0);
        check("midrst_load_err", 16'(load_err), 16'h0);
        cyc();
        load_valid = 1'b0;
        rst = 1'b0;
        cyc();
        core_read(15'h000, "midrst_b0", 8'hA1);
        core_read(15'h001, "midrst_b1", 8'hA2);
        core_read(15'h002, "midrst_b2_untouched", 8'h3E);

        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 8'h5A;
        load_last  = 1'b1;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
        cyc();
        core_read(15'h000, "restart_at_zero", 8'h5A);
        core_read(15'h001, "restart_b1_kept", 8'hA2);

        // loader beats a simultaneous core write
        check("pre_arb_addr_err", 16'(addr_err), 16'h0);
        load_start = 1'b1;
        cyc();
        load_start       = 1'b0;
        load_valid       = 1'b1;
        load_data        = 8'hE1;
        load_last        = 1'b1;
        mem_enable_write = 1'b1;
        mem_addr         = 15'h020;
        mem_data_out     = 8'hD2;
        cyc();
        load_valid       = 1'b0;
        load_last        = 1'b0;
        mem_enable_write = 1'b0;
        check("arb_addr_err", 16'(addr_err), 16'h1);
        core_read(15'h000, "arb_loader_wins", 8'hE1);
        core_read(15'h020, "arb_core_dropped", 8'h1C);
`else
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        load_last  = 1'b1;
        cyc();
        load_start = 1'b0;
        cyc();
        check("noload_ready", 16'(load_ready), 16'h0);
        check("noload_loading", 16'(loading), 16'h0);
        check("noload_err", 16'(load_err), 16'h0);
        load_valid = 1'b0;
        load_last  = 1'b0;
        core_read(15'h000, "noload_array_kept", 8'h09);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
